// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: bit-serial unsigned magnitude comparator.
// The operands are captured when start is accepted, then walked MSB-first at one
// bit pair per clock through a 1-bit equality function. The first differing bit
// pair decides the ordering, and the result is reported as eq/gt/lt with a done pulse.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: when defined, the walk stops at
// the first differing bit instead of always taking W cycles.
module serial_mag_cmp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_eq_q, acc_eq_d;
    logic          acc_gt_q, acc_gt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;

    logic          abit;
    logic          bbit;
    logic          bit_same;
    logic          first_diff;
    logic          shift_exit;

    // 1-bit equality cell, iterated in time rather than replicated W times.
    function automatic logic eq_bit(input logic x, input logic y);
        return (x & y) | (~x & ~y);
    endfunction

    assign abit       = a_q[W-1];
    assign bbit       = b_q[W-1];
    assign bit_same   = eq_bit(abit, bbit);
    // Only the first mismatch counts; once acc_eq drops the decision is frozen.
    assign first_diff = acc_eq_q & ~bit_same;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // Stop as soon as the ordering is known; equal operands still walk all W bits.
    assign shift_exit = (cnt_q == '0) | first_diff;
`else
    // Constant latency: always walk all W bits.
    assign shift_exit = (cnt_q == '0);
`endif

    // Next-state, datapath and result logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_eq_d = acc_eq_q;
        acc_gt_d = acc_gt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = CNT_LAST;
                    acc_eq_d = 1'b1;
                    acc_gt_d = 1'b0;
                end
            end

            S_SHIFT: begin
                if (first_diff) begin
                    acc_eq_d = 1'b0;
                    // abit=1, bbit=0 at the first difference means A > B.
                    acc_gt_d = abit;
                end
                a_d   = {a_q[W-2:0], 1'b0};
                b_d   = {b_q[W-2:0], 1'b0};
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;

                if (shift_exit) begin
                    state_d = S_DONE;
                    // Results are loaded on the edge into DONE so that they are
                    // already valid in the cycle done is high.
                    eq_d    = acc_eq_d;
                    gt_d    = ~acc_eq_d & acc_gt_d;
                    lt_d    = ~acc_eq_d & ~acc_gt_d;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any compare in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_eq_q <= 1'b0;
            acc_gt_q <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_eq_q <= acc_eq_d;
            acc_gt_q <= acc_gt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed testbench for serial_mag_cmp (W=8).
// Expected latencies follow SERIAL_CMP_EARLY_EXIT_EN if it is defined for the build.
module tb_serial_mag_cmp;

    localparam int W = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int LAT_MSB_DIFF  = 2;
    localparam int BUSY_MSB_DIFF = 1;
`else
    localparam int LAT_MSB_DIFF  = 9;
    localparam int BUSY_MSB_DIFF = 8;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Measurements from the most recent run_compare.
    int       r_done_at;
    int       r_done_cnt;
    int       r_busy_cnt;
    logic [2:0] r_res;
    logic     r_hold_bad;

    always #5 clk = ~clk;

    serial_mag_cmp #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    // Pulse start for one cycle with the given operands, then observe 14 cycles.
    // Operands are scrambled after acceptance; results must not depend on them.
    task automatic run_compare(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [2:0] prev;
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        prev = {eq, gt, lt};
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = bv ^ 8'h55;
        r_done_at = 0; r_done_cnt = 0; r_busy_cnt = 0;
        r_res = 3'b000; r_hold_bad = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (busy) r_busy_cnt++;
            if (done) begin
                r_done_cnt++;
                if (r_done_at == 0) begin
                    r_done_at = n;
                    r_res = {eq, gt, lt};
                end
            end else if (r_done_at == 0 && {eq, gt, lt} != prev) begin
                r_hold_bad = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int seen_busy = 0;
        int seen_done = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else pass_cnt++;
        total_cnt++; if ({eq, gt, lt} !== 3'b000) $display("FAIL reset_result eq/gt/lt got %b expected 000", {eq, gt, lt}); else pass_cnt++;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        total_cnt++; if (seen_busy !== 0) $display("FAIL idle_busy cycles got %0d expected 0", seen_busy); else pass_cnt++;
        total_cnt++; if (seen_done !== 0) $display("FAIL idle_done cycles got %0d expected 0", seen_done); else pass_cnt++;
    endtask

    task automatic test_equal();
        run_compare(8'hA5, 8'hA5);
        total_cnt++; if (r_done_at !== 9) $display("FAIL eq_done_at got %0d expected 9", r_done_at); else pass_cnt++;
        total_cnt++; if (r_busy_cnt !== 8) $display("FAIL eq_busy_cycles got %0d expected 8", r_busy_cnt); else pass_cnt++;
        total_cnt++; if (r_done_cnt !== 1) $display("FAIL eq_done_pulses got %0d expected 1", r_done_cnt); else pass_cnt++;
        total_cnt++; if (r_res !== 3'b100) $display("FAIL eq_result eq/gt/lt got %b expected 100", r_res); else pass_cnt++;
        total_cnt++; if (r_hold_bad !== 1'b0) $display("FAIL eq_hold prev result changed before done got %b expected 0", r_hold_bad); else pass_cnt++;
        total_cnt++; if ({eq, gt, lt} !== 3'b100) $display("FAIL eq_held got %b expected 100", {eq, gt, lt}); else pass_cnt++;
    endtask

    task automatic test_gt_msb();
        run_compare(8'h80, 8'h7F);
        total_cnt++; if (r_done_at !== LAT_MSB_DIFF) $display("FAIL gt_done_at got %0d expected %0d", r_done_at, LAT_MSB_DIFF); else pass_cnt++;
        total_cnt++; if (r_busy_cnt !== BUSY_MSB_DIFF) $display("FAIL gt_busy_cycles got %0d expected %0d", r_busy_cnt, BUSY_MSB_DIFF); else pass_cnt++;
        total_cnt++; if (r_done_cnt !== 1) $display("FAIL gt_done_pulses got %0d expected 1", r_done_cnt); else pass_cnt++;
        total_cnt++; if (r_res !== 3'b010) $display("FAIL gt_result eq/gt/lt got %b expected 010", r_res); else pass_cnt++;
        total_cnt++; if (r_hold_bad !== 1'b0) $display("FAIL gt_hold prev result changed before done got %b expected 0", r_hold_bad); else pass_cnt++;
    endtask

    task automatic test_lt_lsb();
        run_compare(8'h00, 8'h01);
        total_cnt++; if (r_done_at !== 9) $display("FAIL lt_done_at got %0d expected 9", r_done_at); else pass_cnt++;
        total_cnt++; if (r_busy_cnt !== 8) $display("FAIL lt_busy_cycles got %0d expected 8", r_busy_cnt); else pass_cnt++;
        total_cnt++; if (r_res !== 3'b001) $display("FAIL lt_result eq/gt/lt got %b expected 001", r_res); else pass_cnt++;
        total_cnt++; if (r_hold_bad !== 1'b0) $display("FAIL lt_hold prev result changed before done got %b expected 0", r_hold_bad); else pass_cnt++;
        run_compare(8'hFF, 8'hFE);
        total_cnt++; if (r_done_at !== 9) $display("FAIL gt_lsb_done_at got %0d expected 9", r_done_at); else pass_cnt++;
        total_cnt++; if (r_res !== 3'b010) $display("FAIL gt_lsb_result eq/gt/lt got %b expected 010", r_res); else pass_cnt++;
    endtask

    // start held high with new operands every cycle: compares accepted at
    // cycles 0, 10, 20 (operand pairs there differ at most in the LSB).
    task automatic test_back_to_back();
        int       dn = 0;
        int       d_at [0:3];
        logic [2:0] d_res [0:3];
        for (int i = 0; i < 4; i++) begin d_at[i] = -1; d_res[i] = 3'b000; end
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            start = 1'b1;
            case (i)
                0:       begin a = 8'h3C; b = 8'h3C; end
                10:      begin a = 8'h10; b = 8'h11; end
                20:      begin a = 8'h21; b = 8'h20; end
                default: begin
                    if (i % 2 == 1) begin a = 8'hFF; b = 8'h00; end
                    else            begin a = 8'h00; b = 8'hFF; end
                end
            endcase
            @(negedge clk);
            if (done) begin
                if (dn < 4) begin d_at[dn] = i; d_res[dn] = {eq, gt, lt}; end
                dn++;
            end
        end
        start = 1'b0;
        total_cnt++; if (dn !== 3) $display("FAIL b2b_done_count got %0d expected 3", dn); else pass_cnt++;
        total_cnt++; if (d_at[0] !== 9) $display("FAIL b2b_done0_at got %0d expected 9", d_at[0]); else pass_cnt++;
        total_cnt++; if (d_res[0] !== 3'b100) $display("FAIL b2b_res0 got %b expected 100", d_res[0]); else pass_cnt++;
        total_cnt++; if (d_at[1] !== 19) $display("FAIL b2b_done1_at got %0d expected 19", d_at[1]); else pass_cnt++;
        total_cnt++; if (d_res[1] !== 3'b001) $display("FAIL b2b_res1 got %b expected 001", d_res[1]); else pass_cnt++;
        total_cnt++; if (d_at[2] !== 29) $display("FAIL b2b_done2_at got %0d expected 29", d_at[2]); else pass_cnt++;
        total_cnt++; if (d_res[2] !== 3'b010) $display("FAIL b2b_res2 got %b expected 010", d_res[2]); else pass_cnt++;
        // Let the compare accepted at cycle 30 (00 vs FF -> lt) finish.
        repeat (12) @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({eq, gt, lt} !== 3'b001) $display("FAIL b2b_tail_result got %b expected 001", {eq, gt, lt}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h5A; start = 1'b1;        // cycle k
        @(posedge clk); #1;
        start = 1'b0;                              // cycle k+1
        repeat (3) @(posedge clk); #1;             // cycle k+4
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b expected 1", busy); else pass_cnt++;
        @(posedge clk); #1;                        // cycle k+5
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL abort_done got %b expected 0", done); else pass_cnt++;
        total_cnt++; if ({eq, gt, lt} !== 3'b000) $display("FAIL abort_result got %b expected 000", {eq, gt, lt}); else pass_cnt++;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        total_cnt++; if (seen_done !== 0) $display("FAIL abort_no_done pulses got %0d expected 0", seen_done); else pass_cnt++;
        run_compare(8'h5B, 8'h5A);
        total_cnt++; if (r_done_at !== 9) $display("FAIL after_abort_done_at got %0d expected 9", r_done_at); else pass_cnt++;
        total_cnt++; if (r_res !== 3'b010) $display("FAIL after_abort_result got %b expected 010", r_res); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_equal();
        test_gt_msb();
        test_lt_lsb();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
